seq_mult_param: RTL and testbench
=================================

// Module: seq_mult_param
// PURPOSE
//   Parametrised sequential multiplier; next generation of the product stage that feeds binary_to_bcd.
//   Radix-2 shift-add on operand magnitudes with sign fix-up at the end.
//   Signed or unsigned operation, selected per operation.
//   start/busy/done handshake; fixed latency independent of operand values.
// PARAMETERS
//   A_W        8   width of operand a
//   B_W        8   width of operand b; also the iteration count
//   ACC_GUARD  8   extra accumulator bits; used only when SEQ_MULT_ACC_EN is defined
//   (local) P_W = A_W+B_W   product width
// PORTS
//   clk      in   1        rising-edge clock
//   reset_n  in   1        asynchronous, active-low reset
//   start    in   1        request; sampled only in IDLE
//   sgn      in   1        1 = two's-complement operands, 0 = unsigned; sampled with start
//   a        in   A_W      multiplicand; sampled with start
//   b        in   B_W      multiplier; sampled with start
//   busy     out  1        high while in CALC or DONE
//   done     out  1        one-cycle pulse; product is valid from this cycle onward
//   product  out  P_W      result; signed when sgn=1; held until the next done
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, product=0, all internal regs=0.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE, start=1 (edge E0):
//     - latch mag_a=|a|, mag_b=|b| (unsigned A_W/B_W bits; -2^(W-1) gives 2^(W-1))
//     - latch neg = sgn & (a[MSB]^b[MSB]); sgn=0 gives neg=0 and mag=raw operand
//     - clear acc[P_W-1:0]; cnt=0; go to CALC
//   CALC (edges E1..E_BW): if mag_b[cnt] then acc += mag_a<<cnt; cnt++.
//     - after edge E_BW (cnt reaches B_W): go to DONE
//   DONE (edge E_BW+1): product <= neg ? -acc : acc (mod 2^P_W); done=1; go to IDLE.
//   done clears at E_BW+2.
//   Latency: start sampled at E0 gives done high in the cycle after E_BW+1.
//   Throughput: a new start is accepted at E_BW+2 (done cycle), i.e. one op per B_W+2 clocks.
//   busy=1 from after E0 through E_BW+1; start while busy is ignored, with no queueing and no error.
//   Operands are not observed after E0; changing a, b or sgn mid-op has no effect.
//   Full range is exact: -2^(A_W-1) * -2^(B_W-1) fits in P_W signed; unsigned max*max fits in P_W.
//   Zero operand: full latency is still taken, product=0, neg is irrelevant (no -0 issue).
//   reset_n low mid-op aborts immediately; done is never pulsed for the aborted op.
// CONFIGURATION
//   SEQ_MULT_ACC_EN defined: multiply-accumulate extension.
//     - adds acc_clr (in, 1, sampled with start)
//     - adds acc_out (out, P_W+ACC_GUARD, reset 0)
//     - at the DONE edge: acc_out <= (acc_clr ? 0 : acc_out) + ext(product)
//     - ext = sign-extend if sgn=1, zero-extend if sgn=0; wraps modulo 2^(P_W+ACC_GUARD)
//     - acc_out updates on the same edge that raises done
//   SEQ_MULT_ACC_EN undefined: acc_clr/acc_out absent, ACC_GUARD unused, no accumulate logic;
//     behaviour otherwise identical.
// TESTING (defaults A_W=B_W=8)
//   1. sgn=1, a=-3, b=5, start 1 clk -> done exactly 10 clks later, product=16'hFFF1 (-15).
//   2. sgn=1, a=-128, b=-128 -> product=16'h4000 (16384); a=-128, b=127 -> 16'hC080 (-16256).
//   3. sgn=0, a=8'hFF, b=8'hFF -> product=16'hFE01 (65025); same operands with sgn=1 -> 16'h0001.
//   4. start held high continuously with a=7, b=6 -> done every 10 clks, product=42;
//      a=9 pulsed while busy -> ignored, product stays 42.
//   5. reset_n low at E4 of an op -> busy, done and product all 0 asynchronously;
//      no done until a new start is given.
//   6. (SEQ_MULT_ACC_EN) acc_clr=1 with 3*4, then acc_clr=0 with -2*5 -> acc_out=12 then 2;
//      acc_clr=1 with 0*9 -> acc_out=0.

Source files
------------

// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//
// Sequential radix-2 shift-add multiplier. It is the product stage in front of
// binary_to_bcd. The datapath multiplies operand magnitudes and applies the sign
// once, when the result is written. Each operation is signed or unsigned,
// selected by sgn. Latency is fixed and does not depend on operand values:
//   - start is sampled at edge E0.
//   - Edges E1..E_BW each perform one shift-add step.
//   - Edge E_BW+1 writes product and raises done.
//   - A new start is accepted in the done cycle, so the core completes one
//     operation every B_W+2 clocks.
//
// Parameters
//   A_W        width of operand a
//   B_W        width of operand b, and the number of shift-add iterations
//   ACC_GUARD  extra accumulator bits for acc_out (multiply-accumulate build only)
//
// Ports
//   clk      in   1                rising-edge clock
//   reset_n  in   1                asynchronous active-low reset
//   start    in   1                operation request, sampled only when idle
//   sgn      in   1                1 = two's-complement operands, 0 = unsigned
//   a        in   A_W              multiplicand, sampled with start
//   b        in   B_W              multiplier, sampled with start
//   acc_clr  in   1                (SEQ_MULT_ACC_EN) clear acc_out before adding
//   acc_out  out  A_W+B_W+ACC_GUARD (SEQ_MULT_ACC_EN) running sum of products
//   busy     out  1                high while an operation is in flight
//   done     out  1                one-cycle pulse when product updates
//   product  out  A_W+B_W          result, held until the next done
//
// Build option
//   SEQ_MULT_ACC_EN  When defined, adds the multiply-accumulate extension
//                    (acc_clr / acc_out). acc_out adds each product,
//                    sign-extended or zero-extended according to sgn. It
//                    updates on the same edge that raises done.
// -----------------------------------------------------------------------------
module seq_mult_param #(
  parameter int A_W       = 8,
  parameter int B_W       = 8,
  parameter int ACC_GUARD = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
`ifdef SEQ_MULT_ACC_EN
  input  logic                 acc_clr,
  output logic [A_W+B_W+ACC_GUARD-1:0] acc_out,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [A_W+B_W-1:0]   product
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Datapath state.
  // addend_reg holds |a| shifted left by the current iteration count.
  // mult_reg holds |b| shifted right, so bit 0 is always the multiplier bit
  // for the current step. This avoids variable bit-indexing.
  logic [P_W-1:0]   addend_reg;
  logic [B_W-1:0]   mult_reg;
  logic [P_W-1:0]   acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_reg;
  logic             done_reg;
  logic [P_W-1:0]   product_reg;

  // Control strobes, decoded from the state in the output process.
  logic load;
  logic step;
  logic finish;
  logic cnt_last;

  // Operand magnitudes. The most negative value maps to 2^(W-1), which still
  // fits in W unsigned bits.
  logic             a_is_neg;
  logic             b_is_neg;
  logic [A_W-1:0]   a_abs;
  logic [B_W-1:0]   b_abs;
  logic [P_W-1:0]   result_next;

  assign a_is_neg = sgn & a[A_W-1];
  assign b_is_neg = sgn & b[B_W-1];
  assign a_abs    = a_is_neg ? (~a + A_W'(1)) : a;
  assign b_abs    = b_is_neg ? (~b + B_W'(1)) : b;

  // Sign fix-up applied once, at write-back. A zero magnitude negates to zero,
  // so a "negative zero" result cannot occur.
  assign result_next = neg_reg ? (~acc_reg + P_W'(1)) : acc_reg;

  assign cnt_last = (cnt_reg == CNT_W'(B_W - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start)    state_next = ST_CALC;
      ST_CALC: if (cnt_last) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state_reg)
      ST_IDLE: load = start;
      ST_CALC: begin
        busy = 1'b1;
        step = 1'b1;
      end
      ST_DONE: begin
        busy   = 1'b1;
        finish = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addend_reg <= '0;
      mult_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
    end else if (load) begin
      addend_reg <= {{B_W{1'b0}}, a_abs};
      mult_reg   <= b_abs;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= sgn & (a[A_W-1] ^ b[B_W-1]);
    end else if (step) begin
      if (mult_reg[0]) begin
        acc_reg <= acc_reg + addend_reg;
      end
      addend_reg <= addend_reg << 1;
      mult_reg   <= mult_reg >> 1;
      cnt_reg    <= cnt_reg + CNT_W'(1);
    end
  end

  // Result register and the done pulse. The pulse lasts exactly the one
  // cycle after the write-back edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      done_reg <= finish;
      if (finish) begin
        product_reg <= result_next;
      end
    end
  end

  assign done    = done_reg;
  assign product = product_reg;

`ifdef SEQ_MULT_ACC_EN
  // ---------------------------------------------------------------------------
  // Multiply-accumulate extension
  // ---------------------------------------------------------------------------
  localparam int ACC_W = P_W + ACC_GUARD;

  // sgn and acc_clr are captured with the operands so that changes on the
  // inputs during an operation do not affect it.
  logic             sgn_reg;
  logic             acc_clr_reg;
  logic [ACC_W-1:0] acc_out_reg;
  logic [ACC_W-1:0] result_ext;

  assign result_ext = sgn_reg ? {{ACC_GUARD{result_next[P_W-1]}}, result_next}
                              : {{ACC_GUARD{1'b0}}, result_next};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sgn_reg     <= 1'b0;
      acc_clr_reg <= 1'b0;
      acc_out_reg <= '0;
    end else begin
      if (load) begin
        sgn_reg     <= sgn;
        acc_clr_reg <= acc_clr;
      end
      if (finish) begin
        acc_out_reg <= (acc_clr_reg ? '0 : acc_out_reg) + result_ext;
      end
    end
  end

  assign acc_out = acc_out_reg;
`endif

endmodule

// File: tb/tb_seq_mult_param.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_param
//
// Self-checking bench for seq_mult_param with A_W = B_W = 8.
//
// A reference model computes products with plain integer arithmetic. Its
// timing is "done appears B_W+1 edges after the accepting edge". A compare
// process checks busy, done, product (and acc_out) against the model on every
// falling edge. Directed vectors also check hand-computed product values and
// latencies.
// -----------------------------------------------------------------------------
module tb_seq_mult_param;

  localparam int A_W   = 8;
  localparam int B_W   = 8;
  localparam int GUARD = 8;
  localparam int P_W   = A_W + B_W;
  localparam int ACC_W = P_W + GUARD;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             sgn = 1'b0;
  logic [A_W-1:0]   a = '0;
  logic [B_W-1:0]   b = '0;
  logic             acc_clr = 1'b0;
  logic             busy;
  logic             done;
  logic [P_W-1:0]   product;
`ifdef SEQ_MULT_ACC_EN
  logic [ACC_W-1:0] acc_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  seq_mult_param #(
    .A_W      (A_W),
    .B_W      (B_W),
    .ACC_GUARD(GUARD)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .sgn    (sgn),
    .a      (a),
    .b      (b),
`ifdef SEQ_MULT_ACC_EN
    .acc_clr(acc_clr),
    .acc_out(acc_out),
`endif
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference product from integer arithmetic, reduced mod 2^P_W.
  function automatic logic [P_W-1:0] ref_product(input logic [A_W-1:0] x,
                                                 input logic [B_W-1:0] y,
                                                 input logic s);
    longint r;
    if (s) r = longint'($signed(x)) * longint'($signed(y));
    else   r = longint'(x) * longint'(y);
    return r[P_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] ref_mac(input logic [ACC_W-1:0] acc,
                                               input logic clr, input logic s,
                                               input logic [P_W-1:0] p);
    longint r;
    longint base;
    base = clr ? 64'sd0 : longint'(acc);
    if (s) r = base + longint'($signed(p));
    else   r = base + longint'(p);
    return r[ACC_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic             m_pending = 1'b0;
  logic             m_done    = 1'b0;
  int               m_left    = 0;
  logic [P_W-1:0]   m_result  = '0;
  logic [P_W-1:0]   m_product = '0;
  logic             m_sgn     = 1'b0;
  logic             m_clr     = 1'b0;
  logic [ACC_W-1:0] m_acc     = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pending <= 1'b0;
      m_done    <= 1'b0;
      m_left    <= 0;
      m_result  <= '0;
      m_product <= '0;
      m_sgn     <= 1'b0;
      m_clr     <= 1'b0;
      m_acc     <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_pending) begin
        if (m_left == 0) begin
          m_pending <= 1'b0;
          m_done    <= 1'b1;
          m_product <= m_result;
          m_acc     <= ref_mac(m_acc, m_clr, m_sgn, m_result);
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_pending <= 1'b1;
        m_left    <= B_W;
        m_result  <= ref_product(a, b, sgn);
        m_sgn     <= sgn;
        m_clr     <= acc_clr;
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("busy", {63'd0, busy}, {63'd0, m_pending});
    check("done", {63'd0, done}, {63'd0, m_done});
    check("product", 64'(product), 64'(m_product));
`ifdef SEQ_MULT_ACC_EN
    check("acc_out", 64'(acc_out), 64'(m_acc));
`endif
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Issues a one-cycle start, scrambles the operands while the operation runs,
  // and waits for done. Then checks latency, product, and the model's own
  // value against the hand-computed constant.
  task automatic run_op(input string name, input logic s, input logic [A_W-1:0] x,
                        input logic [B_W-1:0] y, input logic clr,
                        input logic [P_W-1:0] exp_prod);
    int  cycles;
    bit  seen;
    @(posedge clk);
    #1;
    start   = 1'b1;
    sgn     = s;
    a       = x;
    b       = y;
    acc_clr = clr;
    @(posedge clk);
    #1;
    start   = 1'b0;
    a       = A_W'($urandom);
    b       = B_W'($urandom);
    sgn     = 1'($urandom);
    acc_clr = 1'($urandom);
    cycles  = 0;
    seen    = 0;
    while (!seen && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1;
    end
    if (!seen) begin
      check({name, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      check({name, "_latency"}, 64'(cycles), 64'd10);
      check({name, "_product"}, 64'(product), 64'(exp_prod));
      check({name, "_model"}, 64'(m_product), 64'(exp_prod));
    end
    $display("op %s: sgn=%0d a=%0h b=%0h -> product=%0h after %0d cycles",
             name, s, x, y, product, cycles);
  endtask

  initial begin
    int dcount;
    int last_done;
    int ncyc;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", 64'(product), 64'd0);
    #2 reset_n = 1'b1;

    // Signed and unsigned vectors, including the full-range corners.
    run_op("neg3x5",        1'b1, 8'hFD, 8'h05, 1'b0, 16'hFFF1);
    run_op("m128xm128",     1'b1, 8'h80, 8'h80, 1'b0, 16'h4000);
    run_op("m128x127",      1'b1, 8'h80, 8'h7F, 1'b0, 16'hC080);
    run_op("uFFxFF",        1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_op("sFFxFF",        1'b1, 8'hFF, 8'hFF, 1'b0, 16'h0001);
    run_op("u0x200",        1'b0, 8'h00, 8'hC8, 1'b0, 16'h0000);
    run_op("s0xneg5",       1'b1, 8'h00, 8'hFB, 1'b0, 16'h0000);
    run_op("uFFx1",         1'b0, 8'hFF, 8'h01, 1'b0, 16'h00FF);
    run_op("s127x127",      1'b1, 8'h7F, 8'h7F, 1'b0, 16'h3F01);
    run_op("sneg1x1",       1'b1, 8'hFF, 8'h01, 1'b0, 16'hFFFF);
    run_op("u128x2",        1'b0, 8'h80, 8'h02, 1'b0, 16'h0100);
    run_op("s128x2",        1'b1, 8'h80, 8'h02, 1'b0, 16'hFF00);

    // start held high: back-to-back operations, one every B_W+2 clocks.
    // a=9 pulses mid-operation and must be ignored.
    @(posedge clk);
    #1;
    start = 1'b1;
    sgn   = 1'b0;
    a     = 8'd7;
    b     = 8'd6;
    dcount    = 0;
    last_done = 0;
    ncyc      = 0;
    while (dcount < 3 && ncyc < 60) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 3) a = 8'd9;
      if (ncyc == 4) a = 8'd7;
      if (done) begin
        dcount++;
        check("held_product", 64'(product), 64'd42);
        if (dcount > 1) check("held_interval", 64'(ncyc - last_done), 64'd10);
        $display("held start: done #%0d at cycle %0d product=%0d", dcount, ncyc, product);
        last_done = ncyc;
        if (dcount == 3) start = 1'b0;
      end
    end
    if (dcount < 3) begin
      start = 1'b0;
      check("held_done_timeout", 64'(dcount), 64'd3);
    end
    repeat (2) @(negedge clk);

    // Asynchronous reset during an operation.
    @(posedge clk);
    #1;
    start = 1'b1;
    sgn   = 1'b0;
    a     = 8'd5;
    b     = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", 64'(product), 64'd0);
    $display("abort: busy=%0d done=%0d product=%0h", busy, done, product);
    @(negedge clk);
    #2 reset_n = 1'b1;
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    $display("abort: done pulses after release = %0d", dcount);
    run_op("after_abort", 1'b0, 8'd3, 8'd3, 1'b0, 16'd9);

`ifdef SEQ_MULT_ACC_EN
    // Multiply-accumulate sequence.
    run_op("mac_3x4",  1'b0, 8'd3,  8'd4, 1'b1, 16'd12);
    check("mac_acc_12", 64'(acc_out), 64'd12);
    run_op("mac_m2x5", 1'b1, 8'hFE, 8'd5, 1'b0, 16'hFFF6);
    check("mac_acc_2", 64'(acc_out), 64'd2);
    run_op("mac_0x9",  1'b0, 8'd0,  8'd9, 1'b1, 16'd0);
    check("mac_acc_0", 64'(acc_out), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
